// File: rtl/jtbubl_obj_linebuf_pkg.sv
// Shared constants, write-FSM encoding and helpers for the double-buffered
// object line buffer.
package jtbubl_obj_linebuf_pkg;

    localparam int         HW_DEF     = 9;
    localparam logic [3:0] TRANSP_DEF = 4'hF;
    localparam logic [7:0] BG_COL_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAW  = 2'd2,
        ST_WAIT  = 2'd3
    } wr_state_e;

    function automatic logic is_transp(input logic [7:0] data, input logic [3:0] transp);
        return data[3:0] == transp;
    endfunction

endpackage

// File: rtl/jtbubl_obj_linebuf_if.sv
// Draw bus between the object engine (master) and the line buffer (slave).
interface jtbubl_obj_linebuf_if
    import jtbubl_obj_linebuf_pkg::*;
#(
    parameter int HW = HW_DEF
);
    logic          line_start;
    logic          line_done;
    logic [HW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_we;

    modport master (
        input  line_start,
        output line_done,
        output wr_addr,
        output wr_data,
        output wr_we
    );

    modport slave (
        output line_start,
        input  line_done,
        input  wr_addr,
        input  wr_data,
        input  wr_we
    );
endinterface

// File: rtl/jtbubl_obj_linebuf_rd.sv
// Read side of the line buffer: pixel counter, fetch then erase-behind
// sequencing, and the registered colour index sent to the mixer.
module jtbubl_obj_linebuf_rd
    import jtbubl_obj_linebuf_pkg::*;
#(
    parameter int         HW     = HW_DEF,
    parameter logic [7:0] BG_COL = BG_COL_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pxl_cen,
    input  logic          i_LHBL,
    input  logic          i_LVBL,
    input  logic          i_en,
    input  logic [7:0]    i_rd_data,
    output logic [HW-1:0] o_rd_addr,
    output logic          o_erase_we,
    output logic [HW-1:0] o_erase_addr,
    output logic [7:0]    o_col_addr
);

    logic          r_lhbl;
    logic [HW-1:0] r_cnt;
    logic          r_fetch;
    logic [HW-1:0] r_fetch_addr;
    logic [7:0]    r_pix;
    logic [7:0]    r_col;

    logic          w_rise;
    logic [HW-1:0] w_cnt;
    logic          w_active;

    // A pixel strobe coinciding with the LHBL rise must already see address 0
    assign w_rise   = ~r_lhbl & i_LHBL;
    assign w_cnt    = w_rise ? '0 : r_cnt;
    assign w_active = i_pxl_cen & i_LHBL & i_LVBL & i_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lhbl <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_lhbl <= i_LHBL;
            if (i_pxl_cen && i_LHBL)
                r_cnt <= w_cnt + 1'b1;
            else if (w_rise)
                r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch      <= 1'b0;
            r_fetch_addr <= '0;
        end else begin
            r_fetch <= w_active;
            if (w_active)
                r_fetch_addr <= w_cnt;
        end
    end

    // Fetched data waits in r_pix until the next pixel strobe; blanking flushes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix <= BG_COL;
            r_col <= BG_COL;
        end else begin
            if (i_pxl_cen) begin
                if (w_active) begin
                    r_col <= r_pix;
                end else begin
                    r_col <= BG_COL;
                    r_pix <= BG_COL;
                end
            end
            if (r_fetch)
                r_pix <= i_rd_data;
        end
    end

    assign o_rd_addr    = w_cnt;
    assign o_erase_we   = r_fetch;
    assign o_erase_addr = r_fetch_addr;
    assign o_col_addr   = r_col;

endmodule

// File: rtl/jtbubl_obj_linebuf.sv
// Double-buffered object line buffer: the engine draws one bank while the
// other is scanned out and erased; banks swap on every LHBL falling edge.
module jtbubl_obj_linebuf
    import jtbubl_obj_linebuf_pkg::*;
#(
    parameter int         HW     = HW_DEF,
    parameter logic [3:0] TRANSP = TRANSP_DEF,
    parameter logic [7:0] BG_COL = BG_COL_DEF
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_pxl_cen,
    input  logic                       i_LHBL,
    input  logic                       i_LVBL,
    jtbubl_obj_linebuf_if.slave        draw,
    output logic                       o_ready,
    output logic                       o_ovf,
    output logic [7:0]                 o_col_addr
);

    wr_state_e     r_state;
    wr_state_e     w_next;
    logic [HW-1:0] r_clr_addr;
    logic          r_bank;
    logic          r_lhbl;
    logic          r_lvbl;
    logic          r_en;
    logic          r_ovf;
    logic          r_line_start;
    logic          r_rd_sel;

    logic          w_swap;
    logic          w_lvbl_fall;
    logic          w_clear;
    logic          w_ready;
    logic          w_draw_we;
    logic [HW-1:0] w_rd_addr;
    logic          w_erase_we;
    logic [HW-1:0] w_erase_addr;
    logic [7:0]    w_rd_data;

    assign w_swap      = r_lhbl & ~i_LHBL & (r_state != ST_CLEAR);
    assign w_lvbl_fall = r_lvbl & ~i_LVBL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_CLEAR;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (&r_clr_addr) w_next = ST_IDLE;
            ST_IDLE:  if (w_swap) w_next = ST_DRAW;
            ST_DRAW: begin
                if (w_swap)
                    w_next = ST_DRAW;
                else if (draw.line_done)
                    w_next = ST_WAIT;
            end
            ST_WAIT:  if (w_swap) w_next = ST_DRAW;
            default:  w_next = ST_CLEAR;
        endcase
    end

    // A write landing in the swap clk would hit the bank that just turned into the read bank
    always_comb begin
        w_clear   = (r_state == ST_CLEAR);
        w_ready   = ~w_clear;
        w_draw_we = (r_state == ST_DRAW) && draw.wr_we && !w_swap
                    && !is_transp(draw.wr_data, TRANSP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr   <= '0;
            r_bank       <= 1'b0;
            r_lhbl       <= 1'b0;
            r_lvbl       <= 1'b0;
            r_en         <= 1'b0;
            r_ovf        <= 1'b0;
            r_line_start <= 1'b0;
            r_rd_sel     <= 1'b1;
        end else begin
            r_lhbl       <= i_LHBL;
            r_lvbl       <= i_LVBL;
            r_line_start <= w_swap;
            r_rd_sel     <= ~r_bank;
            if (w_clear)
                r_clr_addr <= r_clr_addr + 1'b1;
            if (w_swap) begin
                r_bank <= ~r_bank;
                r_en   <= 1'b1;
            end
            if (w_swap && r_state == ST_DRAW)
                r_ovf <= 1'b1;
            else if (w_lvbl_fall)
                r_ovf <= 1'b0;
        end
    end

    // r_bank names the bank being drawn; the other one is scanned out and erased
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [7:0]    mem [0:(1<<HW)-1];
        logic          w_we;
        logic [HW-1:0] w_addr;
        logic [7:0]    w_data;
        logic [7:0]    r_q;

        always_comb begin
            w_we   = 1'b0;
            w_addr = r_clr_addr;
            w_data = BG_COL;
            if (w_clear) begin
                w_we = 1'b1;
            end else if (r_bank == 1'(b)) begin
                w_we   = w_draw_we;
                w_addr = draw.wr_addr;
                w_data = draw.wr_data;
            end else begin
                w_we   = w_erase_we;
                w_addr = w_erase_addr;
            end
        end

        always_ff @(posedge clk) begin
            if (w_we)
                mem[w_addr] <= w_data;
            r_q <= mem[w_rd_addr];
        end
    end

    assign w_rd_data = r_rd_sel ? g_bank[1].r_q : g_bank[0].r_q;

    jtbubl_obj_linebuf_rd #(
        .HW     (HW),
        .BG_COL (BG_COL)
    ) u_rd (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pxl_cen    (i_pxl_cen),
        .i_LHBL       (i_LHBL),
        .i_LVBL       (i_LVBL),
        .i_en         (r_en),
        .i_rd_data    (w_rd_data),
        .o_rd_addr    (w_rd_addr),
        .o_erase_we   (w_erase_we),
        .o_erase_addr (w_erase_addr),
        .o_col_addr   (o_col_addr)
    );

    assign draw.line_start = r_line_start;
    assign o_ready         = w_ready;
    assign o_ovf           = r_ovf;

endmodule

// File: tb/tb_jtbubl_obj_linebuf.sv
// Bench for the object line buffer: a small bank model predicts every pixel
// on the mixer output, plus ready, ovf and line_start behaviour.
module tb_jtbubl_obj_linebuf;

    localparam int         HW     = 9;
    localparam int         NPIX   = 16;
    localparam int         NBLANK = 3;
    localparam logic [7:0] BG     = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxlCen = 1'b0;
    logic       lhbl = 1'b0;
    logic       lvbl = 1'b1;
    logic       ready;
    logic       ovf;
    logic [7:0] colAddr;

    jtbubl_obj_linebuf_if #(.HW(HW)) drawBus();

    jtbubl_obj_linebuf #(.HW(HW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pxl_cen  (pxlCen),
        .i_LHBL     (lhbl),
        .i_LVBL     (lvbl),
        .draw       (drawBus),
        .o_ready    (ready),
        .o_ovf      (ovf),
        .o_col_addr (colAddr)
    );

    always #5 clk = ~clk;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] expQ[$];
    logic [7:0] mBank [2][NPIX];
    logic       mWb, mEn, mDrawing, mOvf, mReady;
    logic [7:0] mPrev;
    int         lsSeen = 0;
    int         lsExp = 0;

    always @(negedge clk) if (drawBus.line_start) lsSeen++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NPIX; i++)
                mBank[b][i] = BG;
        mWb = 1'b0; mEn = 1'b0; mDrawing = 1'b0; mOvf = 1'b0; mReady = 1'b0;
        mPrev = BG;
    endtask

    // One pixel slot of 4 clk: predict, strobe, compare the mixer output
    task automatic applyStimulus(input int j, input bit active);
        int rb;
        rb = mWb ? 0 : 1;
        @(negedge clk);
        pxlCen = 1'b1;
        if (active && lvbl && mEn) begin
            expQ.push_back(mPrev);
            mPrev = mBank[rb][j];
            mBank[rb][j] = BG;
        end else begin
            expQ.push_back(BG);
            mPrev = BG;
        end
        @(negedge clk);
        pxlCen = 1'b0;
        checkOutput("col_addr", 32'(colAddr), 32'(expQ.pop_front()));
        repeat (2) @(negedge clk);
    endtask

    task automatic applyDraw(input int addr, input logic [7:0] data);
        @(negedge clk);
        drawBus.wr_addr = HW'(addr);
        drawBus.wr_data = data;
        drawBus.wr_we   = 1'b1;
        if (mDrawing && data[3:0] != 4'hF)
            mBank[mWb ? 1 : 0][addr] = data;
        @(negedge clk);
        drawBus.wr_we = 1'b0;
    endtask

    task automatic lineDone();
        @(negedge clk);
        drawBus.line_done = 1'b1;
        mDrawing = 1'b0;
        @(negedge clk);
        drawBus.line_done = 1'b0;
    endtask

    task automatic activeLine();
        @(negedge clk);
        lhbl = 1'b1;
        @(negedge clk);
        for (int j = 0; j < NPIX; j++)
            applyStimulus(j, 1'b1);
    endtask

    task automatic endLine();
        @(negedge clk);
        lhbl = 1'b0;
        if (mReady) begin
            if (mDrawing) mOvf = 1'b1;
            mDrawing = 1'b1;
            mWb = ~mWb;
            mEn = 1'b1;
            lsExp++;
        end
        for (int j = 0; j < NBLANK; j++)
            applyStimulus(j, 1'b0);
        checkOutput("line_start_count", 32'(lsSeen), 32'(lsExp));
        checkOutput("ovf", 32'(ovf), 32'(mOvf));
    endtask

    task automatic waitReady();
        for (int i = 0; i < 600; i++) begin
            if (ready) break;
            @(negedge clk);
        end
        checkOutput("ready_after_clear", 32'(ready), 32'd1);
        mReady = 1'b1;
    endtask

    initial begin
        drawBus.wr_we = 1'b0;
        drawBus.wr_addr = '0;
        drawBus.wr_data = '0;
        drawBus.line_done = 1'b0;
        modelReset();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_col", 32'(colAddr), 32'(BG));
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (511) @(posedge clk);
        #1 checkOutput("ready_at_511", 32'(ready), 32'd0);
        @(posedge clk);
        #1 checkOutput("ready_at_512", 32'(ready), 32'd1);
        mReady = 1'b1;

        $display("[TB] transparency and first display");
        activeLine(); endLine();
        applyDraw(10, 8'h23); applyDraw(11, 8'h4F); lineDone();
        activeLine(); endLine();
        applyDraw(5, 8'h12); applyDraw(5, 8'h34); lineDone();
        activeLine(); endLine();
        lineDone();
        activeLine(); endLine();
        lineDone();
        $display("[TB] erase-behind and overflow");
        activeLine(); endLine();
        activeLine(); endLine();
        @(negedge clk);
        lvbl = 1'b0;
        mOvf = 1'b0;
        @(negedge clk);
        checkOutput("ovf_lvbl_clear", 32'(ovf), 32'(mOvf));
        lvbl = 1'b1;
        applyDraw(3, 8'h56); lineDone();
        activeLine(); endLine();
        activeLine(); endLine();

        $display("[TB] reset mid-scanline");
        @(negedge clk);
        lhbl = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 4; j++)
            applyStimulus(j, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_col", 32'(colAddr), 32'(BG));
        checkOutput("midreset_ready", 32'(ready), 32'd0);
        checkOutput("midreset_ovf", 32'(ovf), 32'd0);
        modelReset();
        repeat (3) @(negedge clk);
        lhbl = 1'b0;
        rst_n = 1'b1;
        waitReady();
        activeLine(); endLine();
        applyDraw(7, 8'h9A); applyDraw(8, 8'hAF); lineDone();
        activeLine(); endLine();
        lineDone();
        activeLine(); endLine();
        activeLine(); endLine();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
